// File: rtl/alu_control_md_pkg.sv
// alu_control_md_pkg
// Shared encodings for the ALU control decoder and the multiply/divide unit:
// ALUOp codes, ALUControl operation codes, R-type FUNCT values, I-type
// OpCode values and the mult/div operation type.
package alu_control_md_pkg;

  // ALUOp from the main control FSM
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_RTYPE = 2'd2;
  localparam logic [1:0] ALUOP_IMM   = 2'd3;

  // ALUControl operation codes
  localparam logic [3:0] ALUC_AND  = 4'd0;
  localparam logic [3:0] ALUC_OR   = 4'd1;
  localparam logic [3:0] ALUC_ADD  = 4'd2;
  localparam logic [3:0] ALUC_SLL  = 4'd3;
  localparam logic [3:0] ALUC_SRL  = 4'd4;
  localparam logic [3:0] ALUC_LUI  = 4'd5;
  localparam logic [3:0] ALUC_SUB  = 4'd6;
  localparam logic [3:0] ALUC_SLT  = 4'd7;
  localparam logic [3:0] ALUC_NOR  = 4'd8;
  localparam logic [3:0] ALUC_XOR  = 4'd9;
  localparam logic [3:0] ALUC_SRA  = 4'd10;
  localparam logic [3:0] ALUC_SLTU = 4'd11;

  // R-type FUNCT field
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  // I-type OpCode field
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;

  // Values equal FUNCT[1:0] of MULT/MULTU/DIV/DIVU
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  // FUNCT 24..27 share the upper bits 0110
  function automatic logic is_md_funct(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/alu_control_md_md_iter.sv
// md_iter
// Iterative multiply/divide engine: shift-add multiply and restoring divide
// on operand magnitudes, one step per cycle, followed by a sign fix-up cycle.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   go_i              start an operation (only asserted while idle)
//   op_i              MULT/MULTU/DIV/DIVU
//   a_i, b_i          operands
//   busy_o            operation in progress
//   done_o            one-cycle completion pulse (cycle after the write)
//   we_o              hi_o/lo_o valid, write HI/LO at this edge
//   hi_o, lo_o        final sign-corrected result
//
// state | meaning
// IDLE  | waiting for go_i
// RUN   | one multiply or divide step per cycle, counter WIDTH-1 down to 0
// FIX   | sign correction, result written, done raised for next cycle
module md_iter
  import alu_control_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go_i,
  input  md_op_e           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic             neg_q, neg_d;
  logic             sa_q, sa_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic is_signed, sa_in, sb_in, is_div_q;
  assign is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign sa_in     = is_signed & a_i[WIDTH-1];
  assign sb_in     = is_signed & b_i[WIDTH-1];
  assign is_div_q  = (op_q == MD_DIV) || (op_q == MD_DIVU);

  // Multiply: hi accumulates, lo holds the remaining multiplier bits.
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  logic [WIDTH:0]   sum, sh;
  logic [WIDTH-1:0] rem, step_hi, step_lo;
  logic             ge;

  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});
    sh  = {hi_q, lo_q[WIDTH-1]};
    ge  = sh >= {1'b0, mb_q};
    rem = WIDTH'(sh - {1'b0, mb_q});
    if (is_div_q) begin
      step_hi = ge ? rem : sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod;

  always_comb begin
    prod = {hi_q, lo_q};
    if (neg_q) prod = ~prod + 1'b1;
    if (is_div_q) begin
      if (dz_q) begin
        lo_o = '1;
        hi_o = a_q;
      end else begin
        lo_o = mag(lo_q, neg_q);
        hi_o = mag(hi_q, sa_q);
      end
    end else begin
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    dz_d    = dz_q;
    a_d     = a_q;
    mb_d    = mb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go_i) begin
          state_d = S_RUN;
          cnt_d   = CW'(WIDTH - 1);
          op_d    = op_i;
          neg_d   = sa_in ^ sb_in;
          sa_d    = sa_in;
          dz_d    = (b_i == '0);
          a_d     = a_i;
          mb_d    = mag(b_i, sb_in);
          hi_d    = '0;
          lo_d    = mag(a_i, sa_in);
        end
      end
      S_RUN: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      mb_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      a_q     <= a_d;
      mb_q    <= mb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign we_o   = (state_q == S_FIX);
  assign done_o = done_q;

endmodule

// File: rtl/alu_control_md.sv
// alu_control_md
// ALU control decoder with an attached iterative multiply/divide unit and
// HI/LO registers.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   ALUOp, OpCode, FUNCT     decode inputs from the main control FSM / IR
//   start                    execute strobe for mult/div/mthi/mtlo
//   A, B                     rs / rt operand values
//   ALUControl, illegal      combinational decode outputs
//   md_busy, md_done         mult/div in progress / completion pulse
//   HI, LO                   result registers
//   md_result                HI on MFHI, LO on MFLO, else 0
module alu_control_md
  import alu_control_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       FUNCT,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       ALUControl,
  output logic             illegal,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] md_result
);

  always_comb begin
    ALUControl = ALUC_ADD;
    illegal    = 1'b0;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALUC_ADD;
      ALUOP_SUB: ALUControl = ALUC_SUB;
      ALUOP_RTYPE: begin
        case (FUNCT)
          F_AND:           ALUControl = ALUC_AND;
          F_OR:            ALUControl = ALUC_OR;
          F_ADD, F_ADDU:   ALUControl = ALUC_ADD;
          F_SUB, F_SUBU:   ALUControl = ALUC_SUB;
          F_SLT:           ALUControl = ALUC_SLT;
          F_SLTU:          ALUControl = ALUC_SLTU;
          F_NOR:           ALUControl = ALUC_NOR;
          F_XOR:           ALUControl = ALUC_XOR;
          F_SLL:           ALUControl = ALUC_SLL;
          F_SRL:           ALUControl = ALUC_SRL;
          F_SRA:           ALUControl = ALUC_SRA;
          // HI/LO moves and mult/div are legal; the ALU result is unused
          F_MFHI, F_MTHI, F_MFLO, F_MTLO,
          F_MULT, F_MULTU, F_DIV, F_DIVU: ALUControl = ALUC_ADD;
          default:         illegal = 1'b1;
        endcase
      end
      ALUOP_IMM: begin
        case (OpCode)
          OP_LUI:   ALUControl = ALUC_LUI;
          OP_SLTI:  ALUControl = ALUC_SLT;
          OP_SLTIU: ALUControl = ALUC_SLTU;
          OP_ADDI:  ALUControl = ALUC_ADD;
          OP_ANDI:  ALUControl = ALUC_AND;
          OP_ORI:   ALUControl = ALUC_OR;
          OP_XORI:  ALUControl = ALUC_XOR;
          default:  illegal = 1'b1;
        endcase
      end
    endcase
  end

  logic             accept, md_go, md_we;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign accept = start && (ALUOp == ALUOP_RTYPE) && !md_busy;
  assign md_go  = accept && is_md_funct(FUNCT);

  md_iter #(.WIDTH(WIDTH)) u_md_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .go_i   (md_go),
    .op_i   (md_op_e'(FUNCT[1:0])),
    .a_i    (A),
    .b_i    (B),
    .busy_o (md_busy),
    .done_o (md_done),
    .we_o   (md_we),
    .hi_o   (md_hi),
    .lo_o   (md_lo)
  );

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // The engine only writes from FIX, when md_busy blocks any MT* accept
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (md_we) begin
      hi_d = md_hi;
      lo_d = md_lo;
    end else if (accept && FUNCT == F_MTHI) begin
      hi_d = A;
    end else if (accept && FUNCT == F_MTLO) begin
      lo_d = A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;
  assign md_result = (FUNCT == F_MFHI) ? hi_q :
                     (FUNCT == F_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_alu_control_md.sv
module tb_alu_control_md;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ALUOp;
  logic [5:0]  OpCode, FUNCT;
  logic        start, start16;
  logic [31:0] A, B;
  logic [15:0] A16, B16;

  logic [3:0]  ALUControl, ALUControl16;
  logic        illegal, illegal16;
  logic        md_busy, md_done, busy16, done16;
  logic [31:0] HI, LO, md_result;
  logic [15:0] HI16, LO16, md_result16;

  always #5 clk = ~clk;

  alu_control_md #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .OpCode(OpCode), .FUNCT(FUNCT),
    .start(start), .A(A), .B(B), .ALUControl(ALUControl), .illegal(illegal),
    .md_busy(md_busy), .md_done(md_done), .HI(HI), .LO(LO), .md_result(md_result)
  );

  alu_control_md #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .OpCode(OpCode), .FUNCT(FUNCT),
    .start(start16), .A(A16), .B(B16), .ALUControl(ALUControl16), .illegal(illegal16),
    .md_busy(busy16), .md_done(done16), .HI(HI16), .LO(LO16), .md_result(md_result16)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference models ----------------
  int rt_map[int];
  int im_map[int];

  task automatic model_dec(input logic [1:0] op, input logic [5:0] oc, input logic [5:0] f,
                           output logic [3:0] c, output logic il);
    c = 4'd2; il = 1'b0;
    case (op)
      2'd1: c = 4'd6;
      2'd2: begin
        if (rt_map.exists(int'(f))) c = 4'(rt_map[int'(f)]);
        else if (!((f >= 16 && f <= 19) || (f >= 24 && f <= 27))) il = 1'b1;
      end
      2'd3: begin
        if (im_map.exists(int'(oc))) c = 4'(im_map[int'(oc)]);
        else il = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic model32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0; hi = '0; lo = '0;
    case (f)
      6'd24: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      6'd25: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      6'd26: if (b == 0) begin lo = '1; hi = a; end
             else begin p = 64'(sa / sb); lo = p[31:0]; p = 64'(sa % sb); hi = p[31:0]; end
      6'd27: if (b == 0) begin lo = '1; hi = a; end
             else begin lo = a / b; hi = a % b; end
      default: ;
    endcase
  endtask

  task automatic model16(input logic [5:0] f, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] hi, output logic [15:0] lo);
    logic [31:0] p;
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p = '0; hi = '0; lo = '0;
    case (f)
      6'd24: begin p = 32'(sa * sb); hi = p[31:16]; lo = p[15:0]; end
      6'd25: begin p = {16'b0, a} * {16'b0, b}; hi = p[31:16]; lo = p[15:0]; end
      6'd26: if (b == 0) begin lo = '1; hi = a; end
             else begin p = 32'(sa / sb); lo = p[15:0]; p = 32'(sa % sb); hi = p[15:0]; end
      6'd27: if (b == 0) begin lo = '1; hi = a; end
             else begin lo = a / b; hi = a % b; end
      default: ;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          e0;
    string       nm;
  } exp_t;
  exp_t sb[$];
  logic [31:0] model_hi = '0, model_lo = '0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_one_cycle", md_done, 0);
      if (md_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.nm, "_hi"}, HI, e.hi);
          check({e.nm, "_lo"}, LO, e.lo);
          check({e.nm, "_latency"}, cyc - e.e0, 33);
          check({e.nm, "_busy_at_done"}, md_busy, 0);
          model_hi = e.hi;
          model_lo = e.lo;
        end
      end
      prev_done = md_done;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (md_busy && n < 100) begin @(negedge clk); n++; end
    if (md_busy) check({nm, "_idle_timeout"}, 1, 0);
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input string nm);
    exp_t e;
    wait_idle(nm);
    ALUOp = 2'd2; FUNCT = f; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model32(f, a, b, e.hi, e.lo);
    e.e0 = cyc;
    e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((sb.size() != 0 || md_busy) && n < 200) begin @(negedge clk); n++; end
    check({nm, "_drain"}, sb.size(), 0);
  endtask

  task automatic mt(input logic [5:0] f, input logic [31:0] a, input string nm);
    wait_idle(nm);
    ALUOp = 2'd2; FUNCT = f; A = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (f == 6'd17) model_hi = a; else model_lo = a;
    check({nm, "_hi"}, HI, model_hi);
    check({nm, "_lo"}, LO, model_lo);
    check({nm, "_nobusy"}, md_busy, 0);
  endtask

  task automatic mf_check(input string nm);
    @(negedge clk);
    ALUOp = 2'd2;
    FUNCT = 6'd16; #1; check({nm, "_mfhi"}, md_result, model_hi);
    FUNCT = 6'd18; #1; check({nm, "_mflo"}, md_result, model_lo);
    FUNCT = 6'd32; #1; check({nm, "_mf_other"}, md_result, 0);
  endtask

  task automatic dec(input logic [1:0] op, input logic [5:0] oc, input logic [5:0] f,
                     input string nm);
    logic [3:0] c;
    logic il;
    @(negedge clk);
    ALUOp = op; OpCode = oc; FUNCT = f; start = 1'b0;
    #1;
    model_dec(op, oc, f, c, il);
    check({nm, "_ctl"}, ALUControl, c);
    check({nm, "_illegal"}, illegal, il);
  endtask

  task automatic run16(input logic [5:0] f, input logic [15:0] a, input logic [15:0] b,
                       input string nm);
    logic [15:0] eh, el;
    int e0, n;
    @(negedge clk);
    ALUOp = 2'd2; FUNCT = f; A16 = a; B16 = b; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    e0 = cyc;
    model16(f, a, b, eh, el);
    n = 0;
    @(negedge clk);
    while (!done16 && n < 40) begin @(negedge clk); n++; end
    check({nm, "_latency"}, cyc - e0, 17);
    check({nm, "_hi"}, HI16, eh);
    check({nm, "_lo"}, LO16, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom % 20);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rt_map[36] = 0; rt_map[37] = 1; rt_map[32] = 2; rt_map[33] = 2; rt_map[34] = 6;
    rt_map[35] = 6; rt_map[42] = 7; rt_map[43] = 11; rt_map[39] = 8; rt_map[38] = 9;
    rt_map[0] = 3;  rt_map[2] = 4;  rt_map[3] = 10;
    im_map[15] = 5; im_map[10] = 7; im_map[11] = 11; im_map[8] = 2;
    im_map[12] = 0; im_map[13] = 1; im_map[14] = 9;

    rst_n = 1'b0; ALUOp = '0; OpCode = '0; FUNCT = 6'd16; start = 1'b0; start16 = 1'b0;
    A = '0; B = '0; A16 = '0; B16 = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_busy", md_busy, 0);
    check("rst_done", md_done, 0);
    check("rst_mfhi", md_result, 0);
    rst_n = 1'b1;

    // decode: directed then random
    dec(2'd2, 6'd0, 6'd42, "rt_slt");
    dec(2'd2, 6'd0, 6'd3,  "rt_sra");
    dec(2'd2, 6'd0, 6'd63, "rt_f63");
    dec(2'd3, 6'd11, 6'd0, "imm_sltiu");
    dec(2'd3, 6'd4, 6'd0,  "imm_op4");
    dec(2'd2, 6'd0, 6'd25, "rt_multu");
    dec(2'd0, 6'd4, 6'd63, "aluop_add");
    dec(2'd1, 6'd4, 6'd63, "aluop_sub");
    for (int i = 0; i < 300; i++)
      dec(2'($urandom), 6'($urandom), 6'($urandom), "dec_rand");

    // directed mult/div
    issue(6'd24, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
    issue(6'd27, 32'd100, 32'd7, "divu_100_7");
    issue(6'd26, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    issue(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    issue(6'd26, 32'd5, 32'd0, "div_5_0");
    issue(6'd27, 32'hDEAD_BEEF, 32'd0, "divu_x_0");
    issue(6'd26, 32'hFFFF_FFF6, 32'd0, "div_neg_0");
    drain("directed");
    mf_check("after_directed");

    // start while busy is ignored
    issue(6'd25, 32'h1234_5678, 32'h9ABC_DEF0, "multu_busy");
    repeat (5) @(negedge clk);
    ALUOp = 2'd2; FUNCT = 6'd26; A = 32'd9; B = 32'd3; start = 1'b1;
    @(negedge clk);
    FUNCT = 6'd17; A = 32'h5555_AAAA;
    @(negedge clk);
    start = 1'b0;
    drain("busy_start");
    check("busy_start_hi_kept", HI, model_hi);

    // MT*/MF*
    mt(6'd17, 32'h0000_1234, "mthi");
    mf_check("mthi");
    mt(6'd19, 32'hCAFE_F00D, "mtlo");
    mf_check("mtlo");

    // reset mid-DIV
    issue(6'd26, 32'd1000, 32'd3, "div_reset");
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", md_busy, 0);
    check("rst_mid_hi", HI, 0);
    check("rst_mid_lo", LO, 0);
    check("rst_mid_done", md_done, 0);
    sb.delete();
    model_hi = '0; model_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_mid_hi_later", HI, 0);

    // random back-to-back mult/div
    for (int i = 0; i < 40; i++)
      issue(6'(24 + ($urandom % 4)), pick(), pick(), "md_rand");
    drain("random");
    mf_check("after_random");

    // WIDTH=16 instance
    run16(6'd25, 16'hFFFF, 16'hFFFF, "w16_multu_max");
    run16(6'd24, 16'hFFFD, 16'd7, "w16_mult");
    run16(6'd26, 16'h8000, 16'hFFFF, "w16_div_min");
    run16(6'd26, 16'd5, 16'd0, "w16_div0");
    for (int i = 0; i < 8; i++)
      run16(6'(24 + ($urandom % 4)), 16'($urandom), 16'($urandom % 300), "w16_rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
